axi_lite_arbiter: RTL and testbench
===================================

Name: axi_lite_arbiter

Overview:
- Shares one AXI4-Lite master port between NUM_REQ local requesters, each using a simple command/response interface.
- Round-robin grant; one outstanding transaction total.
- Sits between register-access clients (CPU bridge, DMA config, debug) and the single AXI4-Lite interconnect port.
- Payload is latched on grant, so requesters see a single accept pulse and a single response pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- aclk  in  1  clock.
- areset_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester command valid; held until accepted.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i = requester i.
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_wstrb  in  NUM_REQ*DATA_W/8  flattened write strobes.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot one-cycle response pulse; no backpressure.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes.
- rsp_resp  out  2  RRESP/BRESP, valid with rsp_valid.
- awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master channels, ADDR_W/DATA_W wide.

Behaviour:
- Reset (async, areset_n=0):
  - state=IDLE.
  - All AXI valids and readies, req_ready and rsp_valid = 0.
  - Latched addr/data/strb = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has priority first.
  - A reset asserted mid-transaction abandons it: no response pulse; the slave side is assumed reset with the same signal.
- States: IDLE, RADDR, RDATA, WRITE, WRESP, RSP.
- IDLE grant:
  - Combinational search from (last+1) mod NUM_REQ upward, wrapping, for the first req_valid.
  - req_ready[g]=1 in that same cycle, only in IDLE.
  - Registered on that edge: g -> gnt_id, last<=g, addr/wdata/wstrb/write.
  - Next state is WRITE if write, else RADDR.
  - No requests: remain IDLE, req_ready=0.
- Read path:
  - RADDR: arvalid=1, araddr=latched addr; advance to RDATA on arvalid&&arready.
  - RDATA: rready=1; on rvalid, capture rdata/rresp and go to RSP.
- Write path:
  - WRITE: awvalid and wvalid asserted together, each with its own done flag.
  - Each valid drops the cycle after its own handshake, so AW and W may complete in either order or in the same cycle.
  - Advance to WRESP when both done flags are set (including same-cycle completion).
  - WRESP: bready=1; on bvalid, capture bresp, rdata<=0, go to RSP.
- RSP:
  - rsp_valid[gnt_id]=1 for exactly one cycle, with rsp_rdata/rsp_resp stable.
  - Then IDLE.
  - Turnaround: next grant is no earlier than the cycle after RSP.
- Latency at zero-wait slave:
  - Read: accept at cycle 0, arvalid at 1, rready at 2, rsp_valid at 3.
  - Write: accept at 0, aw/w at 1, bready at 2, rsp_valid at 3.
- AXI rules:
  - Payload on any valid channel is stable until its handshake.
  - Valids never depend combinationally on readies.
  - araddr/awaddr/wdata/wstrb read 0 when not valid.
- req_valid for a non-granted requester may drop without effect. The granted payload is ignored after acceptance.
- SLVERR/DECERR are passed through unchanged in rsp_resp; the arbiter never retries.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 transactions.

Test Plan:
- Single read, NUM_REQ=2: req 0 reads 0x4, slave returns 0xDEADBEEF OKAY with zero wait -> arvalid at cycle 1, rsp_valid=2'b01 at cycle 3, rsp_rdata=0xDEADBEEF, rsp_resp=0.
- Write with skewed channels: req 1 writes 0x12345678 strb 0xF to 0x10; awready 3 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles; bready only after both; rsp_valid=2'b10 with rsp_rdata=0.
- Contention: both requesters hold req_valid after reset -> grant order 0,1,0,1 across four transactions; req_ready is always one-hot.
- Error pass-through: slave returns RRESP=2'b10 -> rsp_resp=2'b10, no retry, next grant proceeds normally.
- Reset mid-op: assert areset_n=0 while in RDATA -> all valids and readies low immediately (async), no rsp_valid; after release, requester 0 wins first.
- Back-to-back: requester 0 requests again right after its rsp_valid while requester 1 is idle -> re-granted in the cycle after RSP; AXI valids never overlap between transactions.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NUM_REQ
// command/response clients, with one transaction outstanding at a time.
module axi_lite_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic [ADDR_W-1:0]            awaddr,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [DATA_W-1:0]            wdata,
  output logic [DATA_W/8-1:0]          wstrb,
  output logic                         wvalid,
  input  logic                         wready,
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready,
  output logic [ADDR_W-1:0]            araddr,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rvalid,
  output logic                         rready
);

  localparam int          IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          STRB_W = DATA_W / 8;
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WRITE,
    WRESP,
    RSP
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;

  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_en;
  int unsigned         cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;
  logic                sel_write;

  // Search starts one past the last winner and wraps, giving round-robin order.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned off = 1; off <= NREQ_U; off++) begin
      cand = {{(32-IDX_W){1'b0}}, last_q} + off;
      if (cand >= NREQ_U) cand = cand - NREQ_U;
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Accept pulses are suppressed while reset is held so none escape unregistered.
  assign grant_en = (state_q == IDLE) && areset_n;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_id_d  = gnt_id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          gnt_id_d  = grant_idx;
          last_d    = grant_idx;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          wstrb_d   = sel_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = sel_write ? WRITE : RADDR;
        end
      end
      RADDR: begin
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          resp_d  = rresp;
          state_d = RSP;
        end
      end
      WRITE: begin
        // AW and W complete independently; advance once both have handshaken.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (bvalid) begin
          rdata_d = '0;
          resp_d  = bresp;
          state_d = RSP;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(NREQ_U - 1);
      gnt_id_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_id_q  <= gnt_id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  always_comb begin
    arvalid   = (state_q == RADDR);
    araddr    = arvalid ? addr_q : '0;
    rready    = (state_q == RDATA);
    awvalid   = (state_q == WRITE) && !aw_done_q;
    awaddr    = awvalid ? addr_q : '0;
    wvalid    = (state_q == WRITE) && !w_done_q;
    wdata     = wvalid ? wdata_q : '0;
    wstrb     = wvalid ? wstrb_q : '0;
    bready    = (state_q == WRESP);
    rsp_rdata = rdata_q;
    rsp_resp  = resp_q;
    req_ready = '0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      req_ready[i] = grant_en && grant_found && (grant_idx == IDX_W'(i));
      rsp_valid[i] = (state_q == RSP) && (gnt_id_q == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: transaction-level model checked every
// cycle, plus hand-computed latency/value expectations per scenario.
module tb_axi_lite_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  logic [N-1:0]    req_valid, req_write;
  logic [AW-1:0]   r_addr [N];
  logic [DW-1:0]   r_wdata [N];
  logic [3:0]      r_wstrb [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*4-1:0]  req_wstrb;
  assign req_addr  = {r_addr[1], r_addr[0]};
  assign req_wdata = {r_wdata[1], r_wdata[0]};
  assign req_wstrb = {r_wstrb[1], r_wstrb[0]};

  logic [N-1:0]  req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  axi_lite_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model with per-channel wait states ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic [1:0]    slv_rresp = '0, slv_bresp = '0;

  initial begin
    int  aw_cnt, w_cnt, ar_cnt, r_cnt;
    bit  pend_r, got_aw, got_w, pend_b;
    bit  s_ar, s_r, s_aw, s_w, s_b, s_awx, s_wx, s_arx;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
    pend_r = 0; got_aw = 0; got_w = 0; pend_b = 0;
    awready = 1; wready = 1; arready = 1;
    rvalid = 0; bvalid = 0; rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(negedge aclk);
      s_ar  = arvalid && arready;  s_arx = arvalid && !arready;
      s_aw  = awvalid && awready;  s_awx = awvalid && !awready;
      s_w   = wvalid && wready;    s_wx  = wvalid && !wready;
      s_r   = rvalid && rready;
      s_b   = bvalid && bready;
      @(posedge aclk); #1;
      if (!areset_n) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        pend_r = 0; got_aw = 0; got_w = 0; pend_b = 0;
      end else begin
        if (s_aw) begin aw_cnt = 0; got_aw = 1; end else if (s_awx) aw_cnt++;
        if (s_w)  begin w_cnt = 0;  got_w = 1;  end else if (s_wx)  w_cnt++;
        if (s_ar) ar_cnt = 0; else if (s_arx) ar_cnt++;
        if (s_r) pend_r = 0; else if (pend_r && !rvalid) r_cnt++;
        if (s_ar) begin pend_r = 1; r_cnt = 0; end
        if (s_b) pend_b = 0;
        if (got_aw && got_w) begin pend_b = 1; got_aw = 0; got_w = 0; end
      end
      awready = (aw_cnt >= aw_delay);
      wready  = (w_cnt >= w_delay);
      arready = (ar_cnt >= ar_delay);
      rvalid  = pend_r && (r_cnt >= r_delay);
      rdata   = rvalid ? slv_rdata : '0;
      rresp   = rvalid ? slv_rresp : '0;
      bvalid  = pend_b;
      bresp   = pend_b ? slv_bresp : '0;
    end
  end

  // ---------------- transaction-level reference model ----------------
  bit m_busy, m_write, m_ar, m_aw, m_w, m_wait, m_due;
  int m_id, m_last, m_g;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_strb;
  logic [1:0]    m_resp;

  function automatic int pick(input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_write = 0; m_ar = 0; m_aw = 0; m_w = 0; m_wait = 0; m_due = 0;
    m_id = 0; m_last = N - 1; m_addr = '0; m_wdata = '0; m_strb = '0;
    m_rdata = '0; m_resp = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        model_reset();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_axi_ctl", {arvalid, awvalid, wvalid, rready, bready}, 0);
      end else begin
        m_g = pick(m_last);
        chk("req_ready", req_ready, (!m_busy && m_g >= 0) ? (1 << m_g) : 0);
        chk("rsp_valid", rsp_valid, m_due ? (1 << m_id) : 0);
        if (m_due) begin
          chk("rsp_rdata", rsp_rdata, m_rdata);
          chk("rsp_resp", rsp_resp, m_resp);
        end
        chk("arvalid", arvalid, m_busy && m_ar);
        chk("araddr", araddr, (m_busy && m_ar) ? m_addr : '0);
        chk("awvalid", awvalid, m_busy && m_aw);
        chk("awaddr", awaddr, (m_busy && m_aw) ? m_addr : '0);
        chk("wvalid", wvalid, m_busy && m_w);
        chk("wdata", wdata, (m_busy && m_w) ? m_wdata : '0);
        chk("wstrb", wstrb, (m_busy && m_w) ? m_strb : '0);
        chk("rready", rready, m_busy && m_wait && !m_write);
        chk("bready", bready, m_busy && m_wait && m_write);
        if (m_due) begin
          m_due = 0; m_busy = 0;
        end else if (m_busy) begin
          if (m_wait) begin
            if (!m_write && rvalid) begin
              m_rdata = rdata; m_resp = rresp; m_wait = 0; m_due = 1;
            end else if (m_write && bvalid) begin
              m_rdata = '0; m_resp = bresp; m_wait = 0; m_due = 1;
            end
          end else if (!m_write) begin
            if (m_ar && arready) begin m_ar = 0; m_wait = 1; end
          end else begin
            if (m_aw && awready) m_aw = 0;
            if (m_w && wready) m_w = 0;
            if (!m_aw && !m_w) m_wait = 1;
          end
        end else if (m_g >= 0) begin
          m_busy = 1; m_id = m_g; m_last = m_g;
          m_write = req_write[m_g]; m_addr = r_addr[m_g];
          m_wdata = r_wdata[m_g]; m_strb = r_wstrb[m_g];
          m_ar = !m_write; m_aw = m_write; m_w = m_write; m_wait = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic issue(input int id, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] s);
    req_write[id] = wr; r_addr[id] = a; r_wdata[id] = d; r_wstrb[id] = s;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_rsp(input string name, input logic [N-1:0] exp_v);
    int n;
    n = 0;
    do begin
      tick();
      @(negedge aclk);
      n++;
    end while (rsp_valid == '0 && n < 30);
    chk(name, rsp_valid, exp_v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [4];
    int ng;
    req_valid = '0; req_write = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; r_wstrb[i] = '0;
    end
    areset_n = 0;
    repeat (3) tick();
    areset_n = 1;

    // Single read, zero-wait slave.
    tick();
    slv_rdata = 32'hDEAD_BEEF; slv_rresp = 2'b00;
    issue(0, 1'b0, 32'h4, '0, '0);
    @(negedge aclk); chk("t1_accept", req_ready, 2'b01);
    tick(); req_valid[0] = 1'b0; r_addr[0] = 32'hFFFF_FFF0;
    @(negedge aclk); chk("t1_arvalid_c1", arvalid, 1); chk("t1_araddr_c1", araddr, 32'h4);
    tick();
    @(negedge aclk); chk("t1_rready_c2", rready, 1);
    tick();
    @(negedge aclk);
    chk("t1_rsp_valid_c3", rsp_valid, 2'b01);
    chk("t1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("t1_rsp_resp", rsp_resp, 2'b00);

    // Write with AW accepted three cycles late, W immediately.
    tick();
    aw_delay = 3;
    issue(1, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
    @(negedge aclk); chk("t2_accept", req_ready, 2'b10);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req_valid[1] = 1'b0;
      @(negedge aclk);
      chk("t2_awvalid", awvalid, 1);
      chk("t2_wvalid", wvalid, (c == 1));
      chk("t2_bready_early", bready, 0);
    end
    tick();
    @(negedge aclk); chk("t2_bready_c5", bready, 1); chk("t2_awvalid_c5", awvalid, 0);
    aw_delay = 0;
    tick();
    @(negedge aclk);
    chk("t2_rsp_valid", rsp_valid, 2'b10);
    chk("t2_rsp_rdata_zero", rsp_rdata, 0);

    // SLVERR on read is passed through; no retry, next grant proceeds.
    tick();
    slv_rresp = 2'b10; slv_rdata = 32'hBAD0_0BAD;
    issue(0, 1'b0, 32'h8, '0, '0);
    @(negedge aclk); chk("t3_accept", req_ready, 2'b01);
    tick(); req_valid[0] = 1'b0;
    tick(); tick();
    @(negedge aclk);
    chk("t3_rsp_valid", rsp_valid, 2'b01);
    chk("t3_rsp_resp_slverr", rsp_resp, 2'b10);
    tick();
    slv_rresp = 2'b00;
    issue(1, 1'b0, 32'h20, '0, '0);
    @(negedge aclk);
    chk("t3_next_accept", req_ready, 2'b10);
    chk("t3_no_retry", arvalid, 0);
    tick(); req_valid[1] = 1'b0;
    wait_rsp("t3_next_rsp", 2'b10);
    chk("t3_next_resp_okay", rsp_resp, 2'b00);

    // Contention after reset: both requesters held valid.
    tick();
    areset_n = 0; tick(); tick(); areset_n = 1;
    issue(0, 1'b0, 32'h100, '0, '0);
    issue(1, 1'b0, 32'h200, '0, '0);
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge aclk);
      chk("t4_onehot", $onehot0(req_ready), 1);
      if (req_ready != '0) begin
        order[ng] = (req_ready == 2'b10) ? 1 : 0;
        ng++;
      end
      tick();
    end
    req_valid = '0;
    chk("t4_grant_count", ng, 4);
    chk("t4_grant0", order[0], 0);
    chk("t4_grant1", order[1], 1);
    chk("t4_grant2", order[2], 0);
    chk("t4_grant3", order[3], 1);
    wait_rsp("t4_last_rsp", 2'b10);

    // Reset asserted while waiting in the read-data phase.
    tick();
    r_delay = 20;
    issue(0, 1'b0, 32'h30, '0, '0);
    @(negedge aclk); chk("t5_accept", req_ready, 2'b01);
    tick(); req_valid[0] = 1'b0;
    tick();
    @(negedge aclk); chk("t5_in_rdata", rready, 1);
    req_valid = 2'b11;
    tick();
    areset_n = 0;
    #1;
    chk("t5_async_rready", rready, 0);
    chk("t5_async_ctl", {arvalid, awvalid, wvalid, bready}, 0);
    chk("t5_async_req_ready", req_ready, 0);
    chk("t5_async_rsp_valid", rsp_valid, 0);
    tick(); tick();
    r_delay = 0;
    areset_n = 1;
    @(negedge aclk); chk("t5_first_after_reset", req_ready, 2'b01);
    tick(); req_valid[0] = 1'b0;
    wait_rsp("t5_rsp0", 2'b01);
    tick();
    @(negedge aclk); chk("t5_then_req1", req_ready, 2'b10);
    tick(); req_valid = '0;
    wait_rsp("t5_rsp1", 2'b10);

    // Back-to-back re-grant of requester 0.
    tick();
    slv_rdata = 32'h0000_0040;
    issue(0, 1'b0, 32'h40, '0, '0);
    @(negedge aclk); chk("t6_accept_c0", req_ready, 2'b01);
    tick();
    @(negedge aclk); chk("t6_arvalid_c1", arvalid, 1);
    tick(); tick();
    @(negedge aclk);
    chk("t6_rsp_c3", rsp_valid, 2'b01);
    chk("t6_no_grant_in_rsp", req_ready, 2'b00);
    chk("t6_arvalid_c3", arvalid, 0);
    tick();
    @(negedge aclk);
    chk("t6_regrant_c4", req_ready, 2'b01);
    chk("t6_arvalid_c4", arvalid, 0);
    tick();
    @(negedge aclk); chk("t6_arvalid_c5", arvalid, 1);
    tick(); req_valid = '0;
    wait_rsp("t6_rsp2", 2'b01);

    // Zero-wait write with DECERR response and partial strobe.
    tick();
    slv_bresp = 2'b11;
    issue(1, 1'b1, 32'h44, 32'hA5A5_A5A5, 4'h3);
    @(negedge aclk); chk("t7_accept", req_ready, 2'b10);
    tick(); req_valid[1] = 1'b0;
    @(negedge aclk);
    chk("t7_aw_w_c1", {awvalid, wvalid}, 2'b11);
    chk("t7_awaddr", awaddr, 32'h44);
    chk("t7_wdata", wdata, 32'hA5A5_A5A5);
    chk("t7_wstrb", wstrb, 4'h3);
    tick();
    @(negedge aclk); chk("t7_bready_c2", bready, 1);
    tick();
    @(negedge aclk);
    chk("t7_rsp_c3", rsp_valid, 2'b10);
    chk("t7_rsp_resp", rsp_resp, 2'b11);
    chk("t7_rsp_rdata", rsp_rdata, 0);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
